alu_shift_sequencer: RTL and testbench

//  Initiator side of the shift-ALU interface. Accepts shift requests on a valid/ready port and registers them.

---
 rtl/alu_shift_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_alu_shift_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Shift-ALU initiator: registers requests, drives the ALU, queues results in order.
// Optional amount-range checking is enabled by defining ALU_SHIFT_SEQ_AMT_CHECK_EN.
module alu_shift_sequencer #(
  parameter int WIDTH   = 16,
  parameter int OP_W    = 4,
  parameter int ALU_LAT = 0,
  parameter int DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_err,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] LAT_LAST = 2'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state;
  logic [1:0] lat_cnt;

  logic             hold_vld;
  logic [WIDTH-1:0] hold_data;
  logic [OP_W-1:0]  hold_op;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [OP_W-1:0]  mem_op   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    occ;

  logic             accept;
  logic             sample;
  logic             pop;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;

`ifdef ALU_SHIFT_SEQ_AMT_CHECK_EN
  localparam int WP1 = WIDTH + 1;
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SAR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ROL = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ROR = OP_W'(9);
  localparam logic [WIDTH:0] WV = WP1'(WIDTH);

  logic             big;
  logic             rot;
  logic             fix;
  logic             force_q;
  logic             err_q;
  logic             hold_err;
  logic [WIDTH-1:0] force_val;
  logic             mem_err [DEPTH];

  always_comb begin
    big   = {1'b0, req_b} >= WV;
    rot   = (req_op == OP_ROL) || (req_op == OP_ROR);
    fix   = (req_op == OP_SLL) || (req_op == OP_SAR);
    b_eff = (big && rot) ? WIDTH'({1'b0, req_b} % WV) : req_b;
    res   = force_q ? force_val : alu_result;
  end

  // Out-of-range SLL/SAR results are decided at accept; the ALU still runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_q   <= 1'b0;
      err_q     <= 1'b0;
      force_val <= '0;
    end else if (accept) begin
      force_q   <= big && fix;
      err_q     <= big && (fix || rot);
      force_val <= (req_op == OP_SAR && req_a[WIDTH-1]) ? '1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_err[i] <= 1'b0;
    end else begin
      if (sample) hold_err <= err_q;
      if (hold_vld) mem_err[wr_ptr] <= hold_err;
    end
  end

  assign rsp_err = rsp_valid & mem_err[rd_ptr];
`else
  assign b_eff   = req_b;
  assign res     = alu_result;
  assign rsp_err = 1'b0;
`endif

  assign occ       = count + CW'(hold_vld);
  assign req_ready = rst_n && (state == S_IDLE) && (occ < FULL);
  assign accept    = req_valid && req_ready;
  assign sample    = ((state == S_ISSUE) && (ALU_LAT == 0)) ||
                     ((state == S_WAIT) && (lat_cnt == LAT_LAST));
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_op    = rsp_valid ? mem_op[rd_ptr] : '0;
  assign busy      = (state != S_IDLE) || rsp_valid || hold_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lat_cnt <= 2'd0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_en  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a  <= req_a;
            alu_b  <= b_eff;
            alu_op <= req_op;
            alu_en <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= 2'd0;
          if (ALU_LAT == 0) begin
            state  <= S_IDLE;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            alu_en <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state  <= S_IDLE;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            alu_en <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-cycle holding stage between the ALU sample and the FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      hold_op   <= '0;
    end else begin
      hold_vld <= sample;
      if (sample) begin
        hold_data <= res;
        hold_op   <= alu_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_op[i]   <= '0;
      end
    end else begin
      if (hold_vld) begin
        mem_data[wr_ptr] <= hold_data;
        mem_op[wr_ptr]   <= hold_op;
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      unique case ({hold_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Randomised bench for alu_shift_sequencer with an attached shift-ALU model
// and an arithmetic reference scoreboard.
module tb_alu_shift_sequencer;

  localparam int W   = 16;
  localparam int OPW = 4;
  localparam int LAT = 0;
  localparam int D   = 2;

  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SAR = 4'b0111;
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;

  typedef struct {
    logic [W-1:0]   d;
    logic [OPW-1:0] op;
    logic           e;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic [OPW-1:0] req_op = '0;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic           alu_en;
  logic [W-1:0]   alu_result;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic [OPW-1:0] rsp_op;
  logic           rsp_err;
  logic           busy;

  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];
  logic [W-1:0]   last_a = '0;
  logic [W-1:0]   last_b = '0;
  logic [OPW-1:0] last_op = '0;

  alu_shift_sequencer #(
    .WIDTH(W), .OP_W(OPW), .ALU_LAT(LAT), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_en(alu_en), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational shift ALU: hardware-style, uses only the low amount bits.
  logic [3:0] sh;
  assign sh = alu_b[3:0];
  always_comb begin
    alu_result = '0;
    if (alu_en) begin
      case (alu_op)
        OP_SLL:  alu_result = alu_a << sh;
        OP_SAR:  alu_result = $unsigned($signed(alu_a) >>> sh);
        OP_ROL:  alu_result = (alu_a << sh) | (alu_a >> (5'd16 - {1'b0, sh}));
        OP_ROR:  alu_result = (alu_a >> sh) | (alu_a << (5'd16 - {1'b0, sh}));
        default: alu_result = alu_a + alu_b;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] rol(input logic [W-1:0] a, input int amt);
    longint p;
    p = longint'(1) << amt;
    return W'((longint'(a) * p) % 65536 + longint'(a) / (65536 / p));
  endfunction

  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [OPW-1:0] op);
    exp_t r;
    int amt, sa, q, p;
    amt = int'(b) % W;
    p = 1 << amt;
    r.op = op;
    r.e = 1'b0;
    case (op)
      OP_SLL: r.d = W'((longint'(a) * p) % 65536);
      OP_SAR: begin
        sa = a[W-1] ? int'(a) - 65536 : int'(a);
        q = sa / p;
        if (sa < 0 && q * p != sa) q--;
        r.d = W'(q);
      end
      OP_ROL:  r.d = rol(a, amt);
      OP_ROR:  r.d = rol(a, (W - amt) % W);
      default: r.d = W'((int'(a) + int'(b)) % 65536);
    endcase
`ifdef ALU_SHIFT_SEQ_AMT_CHECK_EN
    if (int'(b) >= W && (op == OP_SLL || op == OP_SAR || op == OP_ROL || op == OP_ROR)) begin
      r.e = 1'b1;
      if (op == OP_SLL) r.d = '0;
      if (op == OP_SAR) r.d = a[W-1] ? 16'hFFFF : 16'h0000;
    end
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] exp_b(input logic [W-1:0] b, input logic [OPW-1:0] op);
`ifdef ALU_SHIFT_SEQ_AMT_CHECK_EN
    if (int'(b) >= W && (op == OP_ROL || op == OP_ROR)) return W'(int'(b) % W);
`endif
    if (op == 4'hF) return b;
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        sb.push_back(ref_model(req_a, req_b, req_op));
        last_a  = req_a;
        last_b  = exp_b(req_b, req_op);
        last_op = req_op;
      end
      if (alu_en) check("alu_drive", {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
      else check("alu_idle", {alu_a, alu_b, alu_op}, 64'd0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp", {rsp_data, rsp_op, rsp_err}, {e.d, e.op, e.e});
        end
      end else if (!rsp_valid) begin
        check("rsp_idle", {rsp_data, rsp_op, rsp_err}, 64'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [OPW-1:0] op);
    int n;
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) check("req_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic acc;
    #3;
    check("rst_out", {req_ready, rsp_valid, alu_en, busy, rsp_data}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);

    // Latency and alu_en width for a single SLL
    rsp_ready = 1'b0;
    send(16'h0001, 16'd4, OP_SLL);
    for (int k = 0; k <= LAT + 2; k++) begin
      @(negedge clk);
      check("lat_en", 64'(alu_en), 64'(k <= LAT));
      check("lat_vld", 64'(rsp_valid), 64'(k == LAT + 2));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    send(16'h8000, 16'd3, OP_SAR);
    send(16'h0001, 16'd1, OP_ROR);
    send(16'h8001, 16'd4, OP_ROL);
    drain();

    // Full FIFO with consumer stalled blocks the third request
    rsp_ready = 1'b0;
    for (int i = 0; i < D; i++) send(16'(i + 3), 16'd2, OP_SLL);
    req_a = 16'h1234;
    req_b = 16'd5;
    req_op = OP_ROR;
    req_valid = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready) cnt++;
    end
    check("full_block", 64'(cnt), 64'd0);
    check("full_state", {rsp_valid, busy}, 64'd3);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!req_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("third_acc", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    // Reset while the op is in ISSUE drops it
    send(16'h00F0, 16'd2, OP_SLL);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid", {rsp_valid, alu_en, busy, req_ready}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_rel", 64'(req_ready), 64'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("no_stale", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;

`ifdef ALU_SHIFT_SEQ_AMT_CHECK_EN
    send(16'hFFFF, 16'd20, OP_SLL);
    send(16'h8000, 16'd16, OP_SAR);
    send(16'h0001, 16'd17, OP_ROL);
    send(16'h0005, 16'd3, OP_SLL);
    drain();
`endif

    // Random traffic with a randomly stalling consumer
    req_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc || !req_valid) begin
        if ($urandom % 3 != 0) begin
          req_valid = 1'b1;
          req_a = 16'($urandom);
          req_b = 16'($urandom % 32);
          case ($urandom % 5)
            0: req_op = OP_SLL;
            1: req_op = OP_SAR;
            2: req_op = OP_ROL;
            3: req_op = OP_ROR;
            default: req_op = 4'($urandom);
          endcase
        end else begin
          req_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("end_empty", {rsp_valid, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
